// File: rtl/iq_age_scheduler_if.sv
// Dispatch / wakeup / issue bundle of one issue-queue bank scheduler.
//   alloc_valid_1/2, alloc_port_1/2 : dispatch slot requests and bound issue port
//   alloc_idx_1/2, alloc_ok         : free entries offered to dispatch
//   free_count                      : number of free entries
//   ready, flush, kill_mask         : wakeup readiness and misprediction recovery
//   grant_valid_0/1, grant_idx_0/1  : registered per-port issue grants
// master = dispatch/wakeup side, slave = scheduler.
interface iq_age_scheduler_if #(
    parameter int unsigned ENT_NUM = 16,
    parameter int unsigned ENT_SEL = 4
);
    logic               alloc_valid_1;
    logic               alloc_valid_2;
    logic               alloc_port_1;
    logic               alloc_port_2;
    logic [ENT_SEL-1:0] alloc_idx_1;
    logic [ENT_SEL-1:0] alloc_idx_2;
    logic               alloc_ok;
    logic [ENT_SEL:0]   free_count;
    logic [ENT_NUM-1:0] ready;
    logic               flush;
    logic [ENT_NUM-1:0] kill_mask;
    logic               grant_valid_0;
    logic               grant_valid_1;
    logic [ENT_SEL-1:0] grant_idx_0;
    logic [ENT_SEL-1:0] grant_idx_1;

    modport master (
        output alloc_valid_1, alloc_valid_2, alloc_port_1, alloc_port_2,
        output ready, flush, kill_mask,
        input  alloc_idx_1, alloc_idx_2, alloc_ok, free_count,
        input  grant_valid_0, grant_valid_1, grant_idx_0, grant_idx_1
    );

    modport slave (
        input  alloc_valid_1, alloc_valid_2, alloc_port_1, alloc_port_2,
        input  ready, flush, kill_mask,
        output alloc_idx_1, alloc_idx_2, alloc_ok, free_count,
        output grant_valid_0, grant_valid_1, grant_idx_0, grant_idx_1
    );
endinterface

// File: rtl/iq_age_scheduler.sv
// Allocation and oldest-first select controller for one issue-queue bank.
// Hands the two lowest free entries to dispatch, tracks relative age with an
// age matrix, picks the oldest ready entry for each of two issue ports and
// registers the grants for the payload-RAM read stage.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : iq_age_scheduler_if.slave (dispatch, wakeup, flush, grants)
module iq_age_scheduler #(
    parameter int unsigned ENT_NUM = 16,
    parameter int unsigned ENT_SEL = 4
) (
    input  logic              clk,
    input  logic              reset,
    iq_age_scheduler_if.slave bus
);

    logic [ENT_NUM-1:0] valid;
    logic [ENT_NUM-1:0] port;
    // older[i][j] = 1 : entry i was allocated before entry j
    logic [ENT_NUM-1:0] older      [ENT_NUM];
    logic [ENT_NUM-1:0] older_next [ENT_NUM];
    logic [ENT_SEL:0]   free_count;
    logic               grant_valid_0;
    logic               grant_valid_1;
    logic [ENT_SEL-1:0] grant_idx_0;
    logic [ENT_SEL-1:0] grant_idx_1;

    logic [ENT_SEL-1:0] idx1;
    logic [ENT_SEL-1:0] idx2;
    logic               found1;
    logic               found2;
    logic               alloc_ok;
    logic               acc1;
    logic               acc2;
    logic [ENT_NUM-1:0] kill;
    logic [ENT_NUM-1:0] cand0;
    logic [ENT_NUM-1:0] cand1;
    logic [ENT_NUM-1:0] win0;
    logic [ENT_NUM-1:0] win1;
    logic [ENT_NUM-1:0] col;
    logic [ENT_SEL-1:0] sel0;
    logic [ENT_SEL-1:0] sel1;
    logic [ENT_NUM-1:0] freed;
    logic [ENT_NUM-1:0] valid_kept;
    logic [ENT_NUM-1:0] alloc_vec;
    logic [ENT_NUM-1:0] port_next;
    logic [ENT_SEL:0]   freed_cnt;
    logic [ENT_SEL:0]   alloc_cnt;

    // Lowest and second-lowest free entries.
    always_comb begin
        idx1   = '0;
        idx2   = '0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            if (!valid[i]) begin
                if (!found1) begin
                    idx1   = ENT_SEL'(i);
                    found1 = 1'b1;
                end else if (!found2) begin
                    idx2   = ENT_SEL'(i);
                    found2 = 1'b1;
                end
            end
        end
    end

    assign alloc_ok = (free_count > (ENT_SEL+1)'(1));
    assign acc1     = bus.alloc_valid_1 & alloc_ok & ~bus.flush;
    assign acc2     = bus.alloc_valid_2 & alloc_ok & ~bus.flush;
    assign kill     = bus.flush ? bus.kill_mask : '0;
    assign cand0    = valid & bus.ready & ~port & ~kill;
    assign cand1    = valid & bus.ready &  port & ~kill;

    // Entry i wins a port when no other candidate on that port is older.
    always_comb begin
        win0 = '0;
        win1 = '0;
        col  = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            for (int unsigned j = 0; j < ENT_NUM; j++) begin
                col[j] = older[j][i];
            end
            win0[i] = cand0[i] & ~|(cand0 & col);
            win1[i] = cand1[i] & ~|(cand1 & col);
        end
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            if (win0[i]) sel0 = ENT_SEL'(i);
            if (win1[i]) sel1 = ENT_SEL'(i);
        end
    end

    // Issued and killed entries are each freed once, even when both apply.
    assign freed      = valid & (win0 | win1 | kill);
    assign valid_kept = valid & ~freed;
    assign alloc_vec  = (acc1 ? (ENT_NUM'(1) << idx1) : '0)
                      | (acc2 ? (ENT_NUM'(1) << idx2) : '0);

    always_comb begin
        freed_cnt = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            freed_cnt = freed_cnt + (ENT_SEL+1)'(freed[i]);
        end
        alloc_cnt = (ENT_SEL+1)'(acc1) + (ENT_SEL+1)'(acc2);
    end

    always_comb begin
        port_next = port;
        if (acc1) port_next[idx1] = bus.alloc_port_1;
        if (acc2) port_next[idx2] = bus.alloc_port_2;
    end

    // New entry: own row cleared, column set from survivors of this cycle's
    // frees; slot 1 is older than slot 2 when both allocate together.
    always_comb begin
        for (int unsigned r = 0; r < ENT_NUM; r++) begin
            older_next[r] = older[r];
            for (int unsigned c = 0; c < ENT_NUM; c++) begin
                if (alloc_vec[r]) begin
                    older_next[r][c] = 1'b0;
                end else if (alloc_vec[c]) begin
                    older_next[r][c] = valid_kept[r];
                end
            end
        end
        if (acc1 && acc2) older_next[idx1][idx2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid         <= '0;
            port          <= '0;
            free_count    <= (ENT_SEL+1)'(ENT_NUM);
            grant_valid_0 <= 1'b0;
            grant_valid_1 <= 1'b0;
            grant_idx_0   <= '0;
            grant_idx_1   <= '0;
            for (int unsigned r = 0; r < ENT_NUM; r++) begin
                older[r] <= '0;
            end
        end else begin
            valid         <= valid_kept | alloc_vec;
            port          <= port_next;
            free_count    <= free_count + freed_cnt - alloc_cnt;
            grant_valid_0 <= |win0;
            grant_valid_1 <= |win1;
            if (|win0) grant_idx_0 <= sel0;
            if (|win1) grant_idx_1 <= sel1;
            for (int unsigned r = 0; r < ENT_NUM; r++) begin
                older[r] <= older_next[r];
            end
        end
    end

    assign bus.alloc_idx_1   = idx1;
    assign bus.alloc_idx_2   = idx2;
    assign bus.alloc_ok      = alloc_ok;
    assign bus.free_count    = free_count;
    assign bus.grant_valid_0 = grant_valid_0;
    assign bus.grant_valid_1 = grant_valid_1;
    assign bus.grant_idx_0   = grant_idx_0;
    assign bus.grant_idx_1   = grant_idx_1;

endmodule

// File: tb/tb_iq_age_scheduler.sv
// Self-checking bench for iq_age_scheduler: directed scenarios plus a
// randomized run against an allocation-timestamp reference model.
module tb_iq_age_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iq_age_scheduler_if #(.ENT_NUM(16), .ENT_SEL(4)) bus ();

    iq_age_scheduler #(.ENT_NUM(16), .ENT_SEL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an entry's age is the sequence number it was given
    // at allocation; the oldest candidate has the smallest number.
    bit m_valid [16];
    bit m_port  [16];
    int m_stamp [16];
    int m_seq;
    bit m_gv    [2];
    int m_gi    [2];

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 16; i++) if (!m_valid[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest_free(input int above);
        for (int i = above + 1; i < 16; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic apply(input bit av1, input bit ap1, input bit av2, input bit ap2,
                         input logic [15:0] rdy, input bit fl, input logic [15:0] km,
                         input bit rst);
        int  w [2];
        int  i1, i2;
        bit  ok, a1, a2;
        bus.alloc_valid_1 = av1;
        bus.alloc_port_1  = ap1;
        bus.alloc_valid_2 = av2;
        bus.alloc_port_2  = ap2;
        bus.ready         = rdy;
        bus.flush         = fl;
        bus.kill_mask     = km;
        reset             = rst;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_port[i] = 0; m_stamp[i] = 0;
            end
            m_seq = 0;
            m_gv[0] = 0; m_gv[1] = 0; m_gi[0] = 0; m_gi[1] = 0;
        end else begin
            ok = (m_free() >= 2);
            i1 = m_lowest_free(-1);
            i2 = (i1 >= 0) ? m_lowest_free(i1) : -1;
            for (int p = 0; p < 2; p++) begin
                w[p] = -1;
                for (int i = 0; i < 16; i++) begin
                    if (m_valid[i] && rdy[i] && (int'(m_port[i]) == p) && !(fl && km[i]))
                        if (w[p] < 0 || m_stamp[i] < m_stamp[w[p]]) w[p] = i;
                end
            end
            for (int i = 0; i < 16; i++) if (fl && km[i]) m_valid[i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_gv[p] = (w[p] >= 0);
                if (w[p] >= 0) begin
                    m_valid[w[p]] = 0;
                    m_gi[p] = w[p];
                end
            end
            a1 = av1 && ok && !fl;
            a2 = av2 && ok && !fl;
            if (a1) begin
                m_valid[i1] = 1; m_port[i1] = ap1; m_stamp[i1] = m_seq; m_seq++;
            end
            if (a2) begin
                m_valid[i2] = 1; m_port[i2] = ap2; m_stamp[i2] = m_seq; m_seq++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
        idle();
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
        apply(1, 0, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1);
        idle();
        checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL reset_free_count: got %0d expected 16", bus.free_count); end
        checks++; if (bus.alloc_ok !== 1'b1) begin errors++; $display("FAIL reset_alloc_ok: got %0b expected 1", bus.alloc_ok); end
        checks++; if (bus.alloc_idx_1 !== 4'd0) begin errors++; $display("FAIL reset_alloc_idx_1: got %0d expected 0", bus.alloc_idx_1); end
        checks++; if (bus.alloc_idx_2 !== 4'd1) begin errors++; $display("FAIL reset_alloc_idx_2: got %0d expected 1", bus.alloc_idx_2); end
        checks++; if (bus.grant_valid_0 !== 1'b0) begin errors++; $display("FAIL reset_grant_valid_0: got %0b expected 0", bus.grant_valid_0); end
        checks++; if (bus.grant_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_grant_valid_1: got %0b expected 0", bus.grant_valid_1); end
        checks++; if (bus.grant_idx_0 !== 4'd0) begin errors++; $display("FAIL reset_grant_idx_0: got %0d expected 0", bus.grant_idx_0); end
    endtask

    task automatic test_age_order();
        int exp_idx [3] = '{0, 1, 2};
        do_reset();
        apply(1, 0, 1, 0, 16'h0, 0, 16'h0, 0);
        apply(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 16'h0007, 0, 16'h0, 0);
            checks++; if (bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL age_grant_valid_0[%0d]: got %0b expected 1", k, bus.grant_valid_0); end
            checks++; if (int'(bus.grant_idx_0) !== exp_idx[k]) begin errors++; $display("FAIL age_grant_idx_0[%0d]: got %0d expected %0d", k, bus.grant_idx_0, exp_idx[k]); end
            checks++; if (bus.grant_valid_1 !== 1'b0) begin errors++; $display("FAIL age_grant_valid_1[%0d]: got %0b expected 0", k, bus.grant_valid_1); end
        end
        idle();
        checks++; if (bus.grant_valid_0 !== 1'b0) begin errors++; $display("FAIL age_drained_grant: got %0b expected 0", bus.grant_valid_0); end
        checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL age_free_count: got %0d expected 16", bus.free_count); end
    endtask

    task automatic test_dual_port();
        do_reset();
        apply(1, 0, 1, 1, 16'h0003, 0, 16'h0, 0);
        checks++; if (bus.grant_valid_0 !== 1'b0) begin errors++; $display("FAIL dual_same_cycle_ready: got %0b expected 0", bus.grant_valid_0); end
        apply(0, 0, 0, 0, 16'h0003, 0, 16'h0, 0);
        checks++; if (bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL dual_grant_valid_0: got %0b expected 1", bus.grant_valid_0); end
        checks++; if (bus.grant_idx_0 !== 4'd0) begin errors++; $display("FAIL dual_grant_idx_0: got %0d expected 0", bus.grant_idx_0); end
        checks++; if (bus.grant_valid_1 !== 1'b1) begin errors++; $display("FAIL dual_grant_valid_1: got %0b expected 1", bus.grant_valid_1); end
        checks++; if (bus.grant_idx_1 !== 4'd1) begin errors++; $display("FAIL dual_grant_idx_1: got %0d expected 1", bus.grant_idx_1); end
        checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL dual_free_count: got %0d expected 16", bus.free_count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(1, 0, 1, 0, 16'h0, 0, 16'h0, 0);
            if (k == 6) begin
                checks++; if (bus.alloc_ok !== 1'b1) begin errors++; $display("FAIL full_two_left_ok: got %0b expected 1", bus.alloc_ok); end
            end
        end
        checks++; if (bus.free_count !== 5'd0) begin errors++; $display("FAIL full_free_count: got %0d expected 0", bus.free_count); end
        checks++; if (bus.alloc_ok !== 1'b0) begin errors++; $display("FAIL full_alloc_ok: got %0b expected 0", bus.alloc_ok); end
        apply(1, 1, 0, 0, 16'h0, 0, 16'h0, 0);
        checks++; if (bus.free_count !== 5'd0) begin errors++; $display("FAIL full_ignored_alloc: got %0d expected 0", bus.free_count); end
        apply(0, 0, 0, 0, 16'hFFFF, 0, 16'h0, 0);
        checks++; if (bus.grant_idx_0 !== 4'd0 || bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL full_oldest_kept: got v%0b idx %0d expected v1 idx 0", bus.grant_valid_0, bus.grant_idx_0); end
        checks++; if (bus.grant_valid_1 !== 1'b0) begin errors++; $display("FAIL full_port1_untouched: got %0b expected 0", bus.grant_valid_1); end
        checks++; if (bus.alloc_idx_1 !== 4'd0) begin errors++; $display("FAIL full_reuse_idx: got %0d expected 0", bus.alloc_idx_1); end
    endtask

    task automatic test_flush();
        do_reset();
        apply(1, 1, 1, 1, 16'h0, 0, 16'h0, 0);
        apply(1, 1, 1, 0, 16'h0, 0, 16'h0, 0);
        apply(1, 1, 1, 0, 16'h0, 0, 16'h0, 0);
        apply(1, 0, 0, 0, 16'h0028, 1, 16'h0008, 0);
        checks++; if (bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL flush_grant_valid_0: got %0b expected 1", bus.grant_valid_0); end
        checks++; if (bus.grant_idx_0 !== 4'd5) begin errors++; $display("FAIL flush_grant_idx_0: got %0d expected 5", bus.grant_idx_0); end
        checks++; if (bus.grant_valid_1 !== 1'b0) begin errors++; $display("FAIL flush_grant_valid_1: got %0b expected 0", bus.grant_valid_1); end
        checks++; if (bus.free_count !== 5'd12) begin errors++; $display("FAIL flush_free_count: got %0d expected 12", bus.free_count); end
        checks++; if (bus.alloc_idx_1 !== 4'd3) begin errors++; $display("FAIL flush_killed_freed: got %0d expected 3", bus.alloc_idx_1); end
        apply(0, 0, 0, 0, 16'h0008, 0, 16'h0, 0);
        checks++; if (bus.grant_valid_0 !== 1'b0) begin errors++; $display("FAIL flush_killed_not_granted: got %0b expected 0", bus.grant_valid_0); end
        checks++; if (bus.grant_idx_0 !== 4'd5) begin errors++; $display("FAIL flush_idx_hold: got %0d expected 5", bus.grant_idx_0); end
    endtask

    task automatic test_reuse();
        do_reset();
        apply(1, 0, 1, 0, 16'h0, 0, 16'h0, 0);
        apply(0, 0, 0, 0, 16'h0001, 0, 16'h0, 0);
        checks++; if (bus.grant_idx_0 !== 4'd0 || bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL reuse_first_issue: got v%0b idx %0d expected v1 idx 0", bus.grant_valid_0, bus.grant_idx_0); end
        checks++; if (bus.alloc_idx_1 !== 4'd0) begin errors++; $display("FAIL reuse_alloc_idx_1: got %0d expected 0", bus.alloc_idx_1); end
        apply(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        apply(0, 0, 0, 0, 16'h0003, 0, 16'h0, 0);
        checks++; if (bus.grant_idx_0 !== 4'd1) begin errors++; $display("FAIL reuse_older_wins: got %0d expected 1", bus.grant_idx_0); end
        apply(0, 0, 0, 0, 16'h0001, 0, 16'h0, 0);
        checks++; if (bus.grant_idx_0 !== 4'd0 || bus.grant_valid_0 !== 1'b1) begin errors++; $display("FAIL reuse_young_issue: got v%0b idx %0d expected v1 idx 0", bus.grant_valid_0, bus.grant_idx_0); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        apply(1, 0, 1, 1, 16'h0, 0, 16'h0, 0);
        apply(0, 0, 0, 0, 16'h0003, 0, 16'h0, 1);
        checks++; if (bus.grant_valid_0 !== 1'b0 || bus.grant_valid_1 !== 1'b0) begin errors++; $display("FAIL midop_reset_grants: got %0b%0b expected 00", bus.grant_valid_0, bus.grant_valid_1); end
        apply(0, 0, 0, 0, 16'h0003, 0, 16'h0, 0);
        checks++; if (bus.grant_valid_0 !== 1'b0) begin errors++; $display("FAIL midop_reset_dropped: got %0b expected 0", bus.grant_valid_0); end
        checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL midop_reset_free: got %0d expected 16", bus.free_count); end
    endtask

    task automatic test_random();
        bit   av1, ap1, av2, ap2, fl, rst;
        logic [15:0] rdy, km;
        int   i1;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (int'(bus.free_count) !== m_free()) begin errors++; $display("FAIL rand_free_count@%0d: got %0d expected %0d", cyc, bus.free_count, m_free()); end
            checks++; if (bus.alloc_ok !== 1'(m_free() >= 2)) begin errors++; $display("FAIL rand_alloc_ok@%0d: got %0b expected %0b", cyc, bus.alloc_ok, m_free() >= 2); end
            if (m_free() >= 2) begin
                i1 = m_lowest_free(-1);
                checks++; if (int'(bus.alloc_idx_1) !== i1) begin errors++; $display("FAIL rand_alloc_idx_1@%0d: got %0d expected %0d", cyc, bus.alloc_idx_1, i1); end
                checks++; if (int'(bus.alloc_idx_2) !== m_lowest_free(i1)) begin errors++; $display("FAIL rand_alloc_idx_2@%0d: got %0d expected %0d", cyc, bus.alloc_idx_2, m_lowest_free(i1)); end
            end
            av1 = 1'($urandom_range(0, 2) != 0);
            av2 = 1'($urandom_range(0, 2) != 0);
            ap1 = 1'($urandom);
            ap2 = 1'($urandom);
            rdy = 16'($urandom & $urandom);
            fl  = ($urandom_range(0, 7) == 0);
            km  = 16'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            apply(av1, ap1, av2, ap2, rdy, fl, km, rst);
            checks++; if (bus.grant_valid_0 !== m_gv[0]) begin errors++; $display("FAIL rand_grant_valid_0@%0d: got %0b expected %0b", cyc, bus.grant_valid_0, m_gv[0]); end
            checks++; if (bus.grant_valid_1 !== m_gv[1]) begin errors++; $display("FAIL rand_grant_valid_1@%0d: got %0b expected %0b", cyc, bus.grant_valid_1, m_gv[1]); end
            checks++; if (int'(bus.grant_idx_0) !== m_gi[0]) begin errors++; $display("FAIL rand_grant_idx_0@%0d: got %0d expected %0d", cyc, bus.grant_idx_0, m_gi[0]); end
            checks++; if (int'(bus.grant_idx_1) !== m_gi[1]) begin errors++; $display("FAIL rand_grant_idx_1@%0d: got %0d expected %0d", cyc, bus.grant_idx_1, m_gi[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_age_order();
        test_dual_port();
        test_full();
        test_flush();
        test_reuse();
        test_midop_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_age_scheduler.md
# iq_age_scheduler

Allocation and oldest-first select controller for one issue-queue bank. It supplies free entry indices to dispatch and tracks entry age with an age matrix. Each cycle it picks the oldest ready entry for each of the two issue ports, frees issued and flushed entries, and registers the two grants for the payload-RAM read stage. It sits beside the wakeup CAM: dispatch writes into the entries it hands out, and the wakeup logic drives its per-entry ready vector.

## Interface
- ENT_NUM, 16, number of issue-queue entries (power of two, ≥4)
- ENT_SEL, 4, log2(ENT_NUM)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- alloc_valid_1 / alloc_valid_2  in  1  dispatch slot 1/2 writes an instruction this cycle
- alloc_port_1 / alloc_port_2  in  1  issue port (0/1) the slot's instruction is bound to
- alloc_idx_1 / alloc_idx_2  out  ENT_SEL  lowest / second-lowest free entry index (combinational from state)
- alloc_ok  out  1  at least two entries free (combinational)
- free_count  out  ENT_SEL+1  number of free entries (registered state)
- ready  in  ENT_NUM  per-entry operands-ready bit from wakeup logic
- flush  in  1  misprediction recovery this cycle
- kill_mask  in  ENT_NUM  entries on the wrong path; honoured only when flush=1
- grant_valid_0 / grant_valid_1  out  1  port 0/1 issued an entry (registered)
- grant_idx_0 / grant_idx_1  out  ENT_SEL  entry issued on port 0/1 (registered)

## Operation
- State: valid[ENT_NUM], port[ENT_NUM], older[ENT_NUM][ENT_NUM]. older[i][j]=1 means i was allocated before j.
- Free search: alloc_idx_1 is the lowest index with valid=0. alloc_idx_2 is the next lowest free index above it. With fewer than two free entries, both indices are don't-care and alloc_ok=0.
- Allocation: a slot is accepted only when alloc_valid_x=1, alloc_ok=1 and flush=0. Slot 1 writes entry alloc_idx_1 and slot 2 writes alloc_idx_2, independently; slot 2 alone is legal.
  - Accepted entry e: valid[e]←1, port[e]←alloc_port_x.
  - Age row: older[e][*]←0.
  - Age column: older[*][e]←valid[*] after this cycle's frees.
  - If both slots are accepted in one cycle, slot 1 is older than slot 2: older[idx1][idx2]←1.
- Eligibility for port p: candidate[i] = valid[i] & ready[i] & port[i]==p & ~(flush & kill_mask[i]).
- Select: entry i wins port p when candidate[i]=1 and no candidate j on port p has older[j][i]=1. This yields at most one winner per port.
- Issue: each winner has valid cleared at the edge. grant_valid_p←1 and grant_idx_p←winner index. With no winner, grant_valid_p←0 and grant_idx_p holds its previous value.
- Flush: every entry with kill_mask=1 has valid cleared. Dispatch allocation is blocked that cycle. Unkilled entries still select and issue normally.
- free_count is updated by +frees −allocs each edge, where frees are issued entries plus killed valid entries (each entry counted once). It never exceeds ENT_NUM.
- The age matrix needs no clearing on free; stale rows are masked by valid.

## Timing
- Reset: valid all 0, older all 0, port all 0, grant_valid_0/1=0, grant_idx_0/1=0, free_count=ENT_NUM, alloc_ok=1, alloc_idx_1=0, alloc_idx_2=1.
- Select-to-grant latency is 1: candidates sampled in cycle N appear on the grant outputs in cycle N+1.
- An entry allocated at edge N is first eligible in cycle N+1 (if ready) and granted at the earliest in cycle N+2.
- An entry issued or killed at edge N shows as free in cycle N+1 and can be reallocated then.
- ready for an entry with valid=0 is ignored.
- ready for an entry being allocated in the same cycle is ignored (valid is still 0).
- Full: with free_count ≤1, alloc_ok=0 and all alloc_valid inputs are ignored; no entry is overwritten.
- Simultaneous flush and issue: a killed entry is never granted, and its valid clears exactly once.
- reset overrides flush and alloc in the same cycle.
- reset asserted mid-operation drops all pending entries; grant_valid is 0 in the following cycle.

## Test plan
- Reset then idle: expect free_count=16, alloc_ok=1, alloc_idx_1=0, alloc_idx_2=1, grant_valid_0/1=0.
- Age order: allocate entries 0,1 (port 0) in one cycle, then 2 (port 0). Hold ready for entries 2,1,0 high. Expect grant_idx_0=0, then 1, then 2 on consecutive cycles, with grant_valid_1=0 throughout.
- Dual port: entries 0 (port 0) and 1 (port 1) are ready in the same cycle. Next cycle expect grant_valid_0=1, grant_idx_0=0, grant_valid_1=1, grant_idx_1=1, and free_count back to 16.
- Full: allocate 16 entries with ready=0. Expect alloc_ok=0 once free_count≤1; a further alloc_valid_1 leaves free_count=0 and the state unchanged.
- Flush: entries 3 and 5 ready on port 0, with 3 older. Apply flush with kill_mask bit 3 set. Expect grant_idx_0=5 next cycle, entry 3 freed, and the same-cycle alloc_valid_1 ignored.
- Reuse: issue entry 0, then allocate in the next cycle. Expect alloc_idx_1=0, and the new entry 0 to be younger than all remaining valid entries (it loses to an older ready entry on the same port).
